// File: rtl/move_sequencer.sv
// Player-square movement sequencer: samples direction keys once per TICK_DIV frames,
// lets the collision flags settle, then commits one clamped step. Option: DIAGONAL_MOVE_EN.
module move_sequencer #(
  parameter int unsigned SIZE     = 20,
  parameter int unsigned STEP     = 2,
  parameter int unsigned X_INIT   = 20,
  parameter int unsigned Y_INIT   = 20,
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned TICK_DIV = 1,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       VGA_clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       colisao_min_y,
  input  logic       colisao_max_y,
  input  logic       colisao_min_x,
  input  logic       colisao_max_x,
  output logic [6:0] tamanho,
  output logic [9:0] xPos,
  output logic [8:0] yPos,
  output logic       moving,
  output logic       blocked
);

  localparam int unsigned AW = 11;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] X_MAX  = AW'(H_RES - SIZE);
  localparam logic [AW-1:0] Y_MAX  = AW'(V_RES - SIZE);
  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MOVE
  } state_t;

  state_t        state;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] settle_cnt;
  logic [3:0]    keys_q;  // {up, down, left, right}

  logic          y_up_c, y_dn_c, x_lt_c, x_rt_c;
  logic          x_hold_c;
  logic          x_blk_c, y_blk_c;
  logic [AW-1:0] x_ext_c, y_ext_c;
  logic [AW-1:0] x_inc_c, x_dec_c, y_inc_c, y_dec_c;
  logic [9:0]    x_nxt_c;
  logic [8:0]    y_nxt_c;

  assign tamanho = 7'(SIZE);

  // Resolve latched keys into at most one request per axis
  always_comb begin
    y_up_c = keys_q[3] & ~keys_q[2];
    y_dn_c = keys_q[2] & ~keys_q[3];
`ifdef DIAGONAL_MOVE_EN
    x_hold_c = 1'b0;
`else
    x_hold_c = y_up_c | y_dn_c;
`endif
    x_lt_c = keys_q[1] & ~keys_q[0] & ~x_hold_c;
    x_rt_c = keys_q[0] & ~keys_q[1] & ~x_hold_c;
  end

  // Candidate positions with saturation at 0 and at the far edge
  always_comb begin
    x_ext_c = AW'(xPos);
    y_ext_c = AW'(yPos);
    x_inc_c = ((x_ext_c + STEP_W) > X_MAX) ? X_MAX : (x_ext_c + STEP_W);
    y_inc_c = ((y_ext_c + STEP_W) > Y_MAX) ? Y_MAX : (y_ext_c + STEP_W);
    x_dec_c = (x_ext_c < STEP_W) ? '0 : (x_ext_c - STEP_W);
    y_dec_c = (y_ext_c < STEP_W) ? '0 : (y_ext_c - STEP_W);

    x_blk_c = (x_lt_c & colisao_min_x) | (x_rt_c & colisao_max_x);
    y_blk_c = (y_up_c & colisao_min_y) | (y_dn_c & colisao_max_y);

    x_nxt_c = xPos;
    if (!x_blk_c && x_lt_c)      x_nxt_c = 10'(x_dec_c);
    else if (!x_blk_c && x_rt_c) x_nxt_c = 10'(x_inc_c);

    y_nxt_c = yPos;
    if (!y_blk_c && y_up_c)      y_nxt_c = 9'(y_dec_c);
    else if (!y_blk_c && y_dn_c) y_nxt_c = 9'(y_inc_c);
  end

  // Sequencer: frame divider, settle wait, single-cycle commit
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      settle_cnt <= '0;
      keys_q     <= '0;
      xPos       <= 10'(X_INIT);
      yPos       <= 9'(Y_INIT);
      moving     <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      blocked <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            if (frame_cnt == CW'(TICK_DIV - 1)) begin
              frame_cnt  <= '0;
              keys_q     <= {key_up, key_down, key_left, key_right};
              settle_cnt <= '0;
              moving     <= 1'b1;
              state      <= ST_SETTLE;
            end else begin
              frame_cnt <= frame_cnt + CW'(1);
            end
          end
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt + CW'(1);
          if (settle_cnt == CW'(SETTLE - 1)) state <= ST_MOVE;
        end
        ST_MOVE: begin
          xPos    <= x_nxt_c;
          yPos    <= y_nxt_c;
          blocked <= x_blk_c | y_blk_c;
          moving  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          moving <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Randomized bench for move_sequencer: two instances (default and TICK_DIV=3 near the edges)
// checked every cycle against a timeline-based reference model plus literal expectations.
module tb_move_sequencer;

  localparam int SIZE   = 20;
  localparam int STEP   = 2;
  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int SETTLE = 2;

  localparam int S_X0 = 0, S_Y0 = 1, S_MV0 = 2, S_BLK0 = 3, S_X1 = 4, S_Y1 = 5, S_BLK1 = 6;

  logic VGA_clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic colisao_min_y = 1'b0, colisao_max_y = 1'b0, colisao_min_x = 1'b0, colisao_max_x = 1'b0;

  logic [6:0] tam0, tam1;
  logic [9:0] x0, x1;
  logic [8:0] y0, y1;
  logic       mv0, mv1, blk0, blk1;

  always #5 VGA_clk = ~VGA_clk;

  move_sequencer u_dut0 (
    .VGA_clk(VGA_clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .colisao_min_y(colisao_min_y), .colisao_max_y(colisao_max_y),
    .colisao_min_x(colisao_min_x), .colisao_max_x(colisao_max_x),
    .tamanho(tam0), .xPos(x0), .yPos(y0), .moving(mv0), .blocked(blk0)
  );

  move_sequencer #(.X_INIT(619), .Y_INIT(1), .TICK_DIV(3)) u_dut1 (
    .VGA_clk(VGA_clk), .rst_n(rst_n), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .colisao_min_y(colisao_min_y), .colisao_max_y(colisao_max_y),
    .colisao_min_x(colisao_min_x), .colisao_max_x(colisao_max_x),
    .tamanho(tam1), .xPos(x1), .yPos(y1), .moving(mv1), .blocked(blk1)
  );

  // Reference model: a step is scheduled SETTLE+1 edges after an accepted tick
  int   mx[2], my[2], tcnt[2], left_c[2];
  bit   busy[2], mblk[2];
  logic [3:0] klat[2];

  function automatic int td(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int mv_axis(input int v, input bit inc, input int lim);
    if (inc) return (v + STEP > lim) ? lim : v + STEP;
    return (v < STEP) ? 0 : v - STEP;
  endfunction

  task automatic model_commit(input int i);
    int ydir, xdir;
    bit yb, xb;
    ydir = (klat[i][2] && !klat[i][3]) ? 1 : ((klat[i][3] && !klat[i][2]) ? -1 : 0);
    xdir = (klat[i][0] && !klat[i][1]) ? 1 : ((klat[i][1] && !klat[i][0]) ? -1 : 0);
`ifdef DIAGONAL_MOVE_EN
    xdir = xdir;
`else
    if (ydir != 0) xdir = 0;
`endif
    yb = (ydir < 0 && colisao_min_y) || (ydir > 0 && colisao_max_y);
    xb = (xdir < 0 && colisao_min_x) || (xdir > 0 && colisao_max_x);
    if (!yb && ydir != 0) my[i] = mv_axis(my[i], ydir > 0, V_RES - SIZE);
    if (!xb && xdir != 0) mx[i] = mv_axis(mx[i], xdir > 0, H_RES - SIZE);
    mblk[i] = yb || xb;
  endtask

  always @(posedge VGA_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mx[i] = (i == 0) ? 20 : 619;
        my[i] = (i == 0) ? 20 : 1;
        tcnt[i] = 0; left_c[i] = 0; busy[i] = 0; mblk[i] = 0; klat[i] = '0;
      end else begin
        mblk[i] = 0;
        if (busy[i]) begin
          left_c[i]--;
          if (left_c[i] == 0) begin
            model_commit(i);
            busy[i] = 0;
          end
        end else if (frame_tick) begin
          tcnt[i]++;
          if (tcnt[i] == td(i)) begin
            tcnt[i] = 0;
            klat[i] = {key_up, key_down, key_left, key_right};
            busy[i] = 1;
            left_c[i] = SETTLE + 1;
          end
        end
      end
    end
  end

  // Literal expectations about the state after the next rising edge
  typedef struct {
    string name;
    int    sel;
    int    val;
  } exp_t;
  exp_t eq[$];

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  function automatic int act(input int sel);
    case (sel)
      S_X0:    return int'(x0);
      S_Y0:    return int'(y0);
      S_MV0:   return int'(mv0);
      S_BLK0:  return int'(blk0);
      S_X1:    return int'(x1);
      S_Y1:    return int'(y1);
      default: return int'(blk1);
    endcase
  endfunction

  task automatic chk(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, a, e, $time);
    end
  endtask

  always @(negedge VGA_clk) begin
    if (chk_en) begin
      chk("x0", int'(x0), mx[0]);   chk("y0", int'(y0), my[0]);
      chk("mv0", int'(mv0), int'(busy[0])); chk("blk0", int'(blk0), int'(mblk[0]));
      chk("x1", int'(x1), mx[1]);   chk("y1", int'(y1), my[1]);
      chk("mv1", int'(mv1), int'(busy[1])); chk("blk1", int'(blk1), int'(mblk[1]));
      chk("tam0", int'(tam0), SIZE); chk("tam1", int'(tam1), SIZE);
      while (eq.size() > 0) begin
        exp_t e;
        e = eq.pop_front();
        chk(e.name, act(e.sel), e.val);
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input int val);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    eq.push_back(e);
  endtask

  task automatic cyc();
    @(negedge VGA_clk);
    #1;
  endtask

  task automatic set_keys(input logic [3:0] k);
    {key_up, key_down, key_left, key_right} = k;
  endtask

  task automatic tick_wait();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    repeat (SETTLE + 2) cyc();
  endtask

  initial begin
    // Reset held with toggling inputs
    rst_n = 1'b0;
    cyc();
    chk_en = 1'b1;
    repeat (2) begin
      set_keys(4'($urandom));
      {colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x} = 4'($urandom);
      frame_tick = 1'($urandom);
      cyc();
    end
    expect_v("rst_x0", S_X0, 20); expect_v("rst_y0", S_Y0, 20);
    expect_v("rst_mv0", S_MV0, 0); expect_v("rst_blk0", S_BLK0, 0);
    expect_v("rst_x1", S_X1, 619); expect_v("rst_y1", S_Y1, 1);
    cyc();
    rst_n = 1'b1; frame_tick = 1'b0; set_keys(4'b0000);
    {colisao_min_y, colisao_max_y, colisao_min_x, colisao_max_x} = 4'b0000;
    cyc();

    // Right step latency
    set_keys(4'b0001);
    frame_tick = 1'b1;
    expect_v("lat_mv_t1", S_MV0, 1); expect_v("lat_x_t1", S_X0, 20);
    cyc();
    frame_tick = 1'b0;
    expect_v("lat_mv_t2", S_MV0, 1);
    cyc();
    expect_v("lat_mv_t3", S_MV0, 1); expect_v("lat_x_t3", S_X0, 20);
    cyc();
    expect_v("lat_x_t4", S_X0, 22); expect_v("lat_y_t4", S_Y0, 20); expect_v("lat_mv_t4", S_MV0, 0);
    cyc();

    // Right clamp on the second instance
    repeat (2) tick_wait();
    expect_v("clamp_x1", S_X1, 620); expect_v("x0_26", S_X0, 26);
    cyc();
    repeat (3) tick_wait();
    expect_v("clamp_hold_x1", S_X1, 620); expect_v("x0_32", S_X0, 32);
    cyc();

    // Down blocked by collision
    set_keys(4'b0100);
    colisao_max_y = 1'b1;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
    expect_v("blk_pre", S_BLK0, 0);
    cyc();
    expect_v("blk_pulse", S_BLK0, 1); expect_v("blk_y0", S_Y0, 20);
    cyc();
    expect_v("blk_post", S_BLK0, 0);
    cyc();
    colisao_max_y = 1'b0;
    tick_wait();
    expect_v("down_y0", S_Y0, 22);
    cyc();

    // Up, with second instance saturating at 0
    set_keys(4'b1000);
    tick_wait();
    expect_v("up_y1", S_Y1, 0); expect_v("up_y0", S_Y0, 20);
    cyc();
    repeat (3) tick_wait();
    expect_v("up_hold_y1", S_Y1, 0); expect_v("up_y0_14", S_Y0, 14);
    cyc();

    // up+down conflict, then up+right priority
    set_keys(4'b1100);
    tick_wait();
    expect_v("conf_y0", S_Y0, 14); expect_v("conf_x0", S_X0, 32);
    cyc();
    set_keys(4'b1001);
    tick_wait();
    expect_v("prio_y0", S_Y0, 12);
`ifdef DIAGONAL_MOVE_EN
    expect_v("prio_x0", S_X0, 34);
`else
    expect_v("prio_x0", S_X0, 32);
`endif
    cyc();

    // Reset during SETTLE aborts the step
    set_keys(4'b0001);
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    rst_n = 1'b0;
    expect_v("abort_mv0", S_MV0, 0);
    cyc();
    rst_n = 1'b1;
    repeat (4) cyc();
    expect_v("abort_x0", S_X0, 20); expect_v("abort_blk0", S_BLK0, 0);
    cyc();

    // TICK_DIV=3 with a tick injected during SETTLE
    set_keys(4'b0010);
    repeat (2) tick_wait();
    frame_tick = 1'b1;
    cyc();
    cyc();
    frame_tick = 1'b0;
    repeat (4) cyc();
    repeat (2) tick_wait();
    expect_v("div_x1", S_X1, 617); expect_v("div_x0", S_X0, 10);
    cyc();

    // Randomized run
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 19) == 0) set_keys(4'($urandom));
      colisao_min_y = ($urandom_range(0, 7) == 0);
      colisao_max_y = ($urandom_range(0, 7) == 0);
      colisao_min_x = ($urandom_range(0, 7) == 0);
      colisao_max_x = ($urandom_range(0, 7) == 0);
      frame_tick = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      cyc();
    end
    rst_n = 1'b1;
    frame_tick = 1'b0;
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
